// File: rtl/uart_tx_frm.sv
// UART frame transmitter with input FIFO: start bit, DW data bits, optional even parity, STOP stop bits.
// Build option: define UART_TX_PARITY_EN to send a parity bit between the data and stop bits.
module uart_tx_frm #(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int DIV       = 868,
  parameter int MSB_FIRST = 1,
  parameter int STOP      = 1
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  input  logic [DW-1:0]          tx_data,
  input  logic                   tx_vld,
  output logic                   tx_rdy,
  output logic                   uart_tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  // state | meaning
  // IDLE  | line high, waiting for a word in the FIFO
  // START | start bit (low)
  // DATA  | DW data bits from the shift register
  // PAR   | even parity bit (only with UART_TX_PARITY_EN)
  // STOP  | STOP stop bits (high); pops the next word at the end if one is queued

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(DW);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [DW-1:0] head;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DW-1:0] shreg;
  logic          baud_end;
  logic          frame_done;
  logic          cur_bit;
  logic          line_val;
`ifdef UART_TX_PARITY_EN
  logic          par_bit;
`endif

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign tx_rdy   = !full;
  assign fifo_cnt = wr_ptr - rd_ptr;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign push     = tx_vld && !full && !rst;

  assign baud_end   = (baud_cnt == BAUD_LAST);
  assign frame_done = (state == S_STOP) && baud_end && (bit_cnt == STOP_LAST);
  assign pop        = !rst && !empty && ((state == S_IDLE) || frame_done);
  assign busy       = (state != S_IDLE) || !empty;
  assign cur_bit    = (MSB_FIRST != 0) ? shreg[DW-1] : shreg[0];

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= tx_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    line_val = 1'b1;
    case (state)
      S_START: line_val = 1'b0;
      S_DATA:  line_val = cur_bit;
`ifdef UART_TX_PARITY_EN
      S_PAR:   line_val = par_bit;
`endif
      default: line_val = 1'b1;
    endcase
  end

  // uart_tx lags the state by one cycle, so the line goes low the edge after the pop
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      uart_tx <= line_val;
      if (pop) begin
        shreg <= head;
`ifdef UART_TX_PARITY_EN
        par_bit <= ^head;
`endif
      end
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (!empty) state <= S_START;
        end
        S_START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (MSB_FIRST != 0) shreg <= {shreg[DW-2:0], 1'b0};
            else                shreg <= {1'b0, shreg[DW-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= S_PAR;
`else
              state   <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PAR: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= empty ? S_IDLE : S_START;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frm.sv
// Bench for uart_tx_frm: two instances (MSB-first/1 stop, LSB-first/2 stop) against a frame-timeline model.
`timescale 1ns/1ps
module tb_uart_tx_frm;
  localparam int NI    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIV   = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic          clk_sys = 1'b0;
  logic          rst;
  logic [DW-1:0] tx_data  [NI];
  logic          tx_vld   [NI];
  logic          tx_rdy   [NI];
  logic          uart_tx  [NI];
  logic          busy     [NI];
  logic [2:0]    fifo_cnt [NI];

  always #5 clk_sys = ~clk_sys;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_frm #(
      .DW(DW), .DEPTH(DEPTH), .DIV(DIV),
      .MSB_FIRST((g == 0) ? 1 : 0), .STOP((g == 0) ? 1 : 2)
    ) u_dut (
      .clk_sys (clk_sys),
      .rst     (rst),
      .tx_data (tx_data[g]),
      .tx_vld  (tx_vld[g]),
      .tx_rdy  (tx_rdy[g]),
      .uart_tx (uart_tx[g]),
      .busy    (busy[g]),
      .fifo_cnt(fifo_cnt[g])
    );
  end

  int checks = 0;
  int errors = 0;

  // model: list of queued words plus the bit list and cycle position of the frame on the line
  logic [DW-1:0] m_q    [NI][DEPTH];
  int            m_cnt  [NI];
  bit            m_act  [NI];
  int            m_pos  [NI];
  bit            m_bits [NI][16];
  bit            e_tx   [NI];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int n_stop(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int frame_len(input int i);
    return DIV * (1 + DW + P + n_stop(i));
  endfunction

  task automatic load_frame(input int i, input logic [DW-1:0] w);
    m_bits[i][0] = 1'b0;
    for (int k = 0; k < DW; k++)
      m_bits[i][1+k] = (i == 0) ? w[DW-1-k] : w[k];
    if (P == 1) m_bits[i][1+DW] = ^w;
    for (int s = 0; s < n_stop(i); s++)
      m_bits[i][1+DW+P+s] = 1'b1;
  endtask

  task automatic model_edge(input int i);
    bit do_push;
    bit fin;
    if (rst) begin
      m_cnt[i] = 0;
      m_act[i] = 0;
      m_pos[i] = 0;
      e_tx[i]  = 1'b1;
    end else begin
      e_tx[i]  = m_act[i] ? m_bits[i][m_pos[i] / DIV] : 1'b1;
      do_push  = tx_vld[i] && (m_cnt[i] < DEPTH);
      fin      = m_act[i] && (m_pos[i] == frame_len(i) - 1);
      if (m_act[i]) m_pos[i]++;
      if ((!m_act[i] || fin) && m_cnt[i] > 0) begin
        load_frame(i, m_q[i][0]);
        for (int k = 0; k < DEPTH - 1; k++) m_q[i][k] = m_q[i][k+1];
        m_cnt[i]--;
        m_act[i] = 1;
        m_pos[i] = 0;
      end else if (fin) begin
        m_act[i] = 0;
      end
      if (do_push) begin
        m_q[i][m_cnt[i]] = tx_data[i];
        m_cnt[i]++;
      end
    end
  endtask

  task automatic tick();
    for (int i = 0; i < NI; i++) model_edge(i);
    @(posedge clk_sys);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("tx%0d", i),   int'(uart_tx[i]),  int'(e_tx[i]));
      check($sformatf("cnt%0d", i),  int'(fifo_cnt[i]), m_cnt[i]);
      check($sformatf("rdy%0d", i),  int'(tx_rdy[i]),   int'(m_cnt[i] < DEPTH));
      check($sformatf("busy%0d", i), int'(busy[i]),     int'(m_act[i] || m_cnt[i] > 0));
    end
  endtask

  task automatic set_vld(input bit v);
    for (int i = 0; i < NI; i++) tx_vld[i] = v;
  endtask

  task automatic push_both(input logic [DW-1:0] d);
    set_vld(1'b1);
    for (int i = 0; i < NI; i++) tx_data[i] = d;
    tick();
    set_vld(1'b0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((busy[0] || busy[1]) && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", int'(busy[0] || busy[1]), 0);
  endtask

  initial begin : stim
    logic [11:0] seq0;
    logic [11:0] seq1;
    logic [11:0] exp0;
    int          acc;

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      tx_vld[i]  = 1'b0;
      tx_data[i] = '0;
    end
    repeat (3) tick();
    check("rst_tx",   int'(uart_tx[0]),  1);
    check("rst_cnt",  int'(fifo_cnt[0]), 0);
    check("rst_rdy",  int'(tx_rdy[0]),   1);
    check("rst_busy", int'(busy[0]),     0);
    rst = 1'b0;
    tick();

    // single frames: 0xAA MSB first on inst 0, 0x01 LSB first on inst 1
    tx_data[0] = 8'hAA;
    tx_data[1] = 8'h01;
    set_vld(1'b1);
    tick();
    set_vld(1'b0);
    tick();
    seq0 = '0;
    seq1 = '0;
    for (int b = 0; b < 12; b++) begin
      tick();
      seq0[b] = uart_tx[0];
      seq1[b] = uart_tx[1];
      repeat (DIV - 1) tick();
    end
    exp0 = (P == 1) ? 12'hCAA : 12'hEAA;
    check("seq_aa", int'(seq0), int'(exp0));
    check("seq_01", int'(seq1), 32'hE02);
    drain(300);

    // back-to-back frames
    push_both(8'h11);
    check("b2b_cnt1", int'(fifo_cnt[0]), 1);
    push_both(8'h22);
    check("b2b_cnt2", int'(fifo_cnt[0]), 1);
    push_both(8'h33);
    check("b2b_cnt3", int'(fifo_cnt[0]), 2);
    drain(300);

    // hold valid for 8 cycles against a 4-deep FIFO
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      set_vld(1'b1);
      for (int i = 0; i < NI; i++) tx_data[i] = 8'($urandom);
      if (tx_rdy[0]) acc++;
      tick();
    end
    set_vld(1'b0);
    check("hold_acc", acc, 5);
    check("hold_rdy", int'(tx_rdy[0]), 0);
    drain(600);

    // reset in the 3rd data bit with two words queued
    push_both(8'hC3);
    push_both(8'h3C);
    push_both(8'h96);
    repeat (3 * DIV) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmid_tx",   int'(uart_tx[0]),  1);
    check("rmid_cnt",  int'(fifo_cnt[0]), 0);
    check("rmid_busy", int'(busy[0]),     0);
    check("rmid_cnt1", int'(fifo_cnt[1]), 0);
    push_both(8'h5A);
    drain(300);

    // random traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NI; i++) begin
        tx_vld[i]  = ($urandom_range(0, 3) == 0);
        tx_data[i] = 8'($urandom);
      end
      rst = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0;
    set_vld(1'b0);
    drain(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
